// File: rtl/game_pkg.sv
// game_pkg: shared scheduler state type and LFSR seeding constants.
package game_pkg;
  typedef enum logic [1:0] {SEED, WARM, IDLE, SCAN} sched_state_t;
  localparam int RW_DEF = 6;
  localparam logic [RW_DEF-1:0] SEED_FALLBACK = 6'b000001;
endpackage

// File: rtl/lane_gap_counter.sv
// lane_gap_counter: per-lane saturating tick counter; eligible once GAP_MIN ticks have passed since the last spawn.
module lane_gap_counter #(
  parameter int GAP_MIN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic eligible
);
  logic [3:0] gap;
  assign eligible = gap == 4'(GAP_MIN);
  always_ff @(posedge clock) begin
    if (reset) gap <= 4'(GAP_MIN);
    else if (clear) gap <= '0;
    else if (tick && !eligible) gap <= gap + 4'd1;
  end
endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: round-robin obstacle spawner sharing one LFSR; optional SPAWN_SCHED_STATS_EN adds spawn/reseed counters.
module spawn_scheduler
  import game_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int GAP_MIN = 3,
  parameter int RW      = RW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               enable,
  input  logic [RW-1:0]      seed,
  input  logic [RW-1:0]      rnd,
  output logic               rng_load,
  output logic [RW-1:0]      rng_start,
  input  logic [LANES*RW-1:0] density,
  output logic [LANES-1:0]   spawn,
  output logic               busy
`ifdef SPAWN_SCHED_STATS_EN
  ,
  output logic [15:0]        spawn_total,
  output logic [7:0]         rng_reseeds
`endif
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  sched_state_t state, state_n;
  logic warm, warm_n;
  logic [IW-1:0] ptr, ptr_n, idx, idx_n, cnt, cnt_n;
  logic pending, pending_n, fire, zero;
  logic [LANES-1:0] eligible, clear, spawn_n;
  assign zero      = rnd == '0;
  assign fire      = eligible[idx] && (rnd < density[idx*RW +: RW]);
  assign busy      = state != IDLE;
  assign rng_load  = (state == SEED) && !reset;
  assign rng_start = seed == '0 ? RW'(SEED_FALLBACK) : seed;
  for (genvar i = 0; i < LANES; i++) begin : g_gap
    lane_gap_counter #(.GAP_MIN(GAP_MIN)) u_gap (
      .clock(clock), .reset(reset), .tick(tick), .clear(clear[i]), .eligible(eligible[i])
    );
  end
  always_comb begin
    state_n   = state;
    warm_n    = 1'b0;
    ptr_n     = ptr;
    idx_n     = idx;
    cnt_n     = cnt;
    pending_n = pending | (tick & busy);
    spawn_n   = '0;
    clear     = '0;
    case (state)
      SEED: state_n = WARM;
      WARM: begin
        warm_n  = !warm;
        state_n = warm ? IDLE : WARM;
      end
      IDLE: if ((tick || pending) && enable) begin
        pending_n = 1'b0;
        idx_n     = ptr;
        cnt_n     = '0;
        state_n   = SCAN;
      end
      SCAN: if (zero) begin
        // LFSR locked at zero: abandon the round and rerun it after reseeding
        state_n   = SEED;
        pending_n = 1'b1;
      end else if (fire) begin
        spawn_n[idx] = 1'b1;
        clear[idx]   = 1'b1;
        ptr_n        = idx == IW'(LANES-1) ? '0 : idx + 1'b1;
        state_n      = IDLE;
      end else begin
        idx_n   = idx == IW'(LANES-1) ? '0 : idx + 1'b1;
        cnt_n   = cnt + 1'b1;
        state_n = cnt == IW'(LANES-1) ? IDLE : SCAN;
      end
      default: state_n = SEED;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= SEED;
      warm    <= 1'b0;
      ptr     <= '0;
      idx     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      spawn   <= '0;
    end else begin
      state   <= state_n;
      warm    <= warm_n;
      ptr     <= ptr_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      spawn   <= spawn_n;
    end
  end
`ifdef SPAWN_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      spawn_total <= '0;
      rng_reseeds <= '0;
    end else begin
      if (|spawn && spawn_total != 16'hFFFF) spawn_total <= spawn_total + 16'd1;
      if (state == SCAN && zero && rng_reseeds != 8'hFF) rng_reseeds <= rng_reseeds + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: randomized stimulus checked against a queue-based behavioural model of the scheduler.
module tb_spawn_scheduler;
  localparam int LANES = 4;
  localparam int GAP   = 3;
  localparam int RW    = 6;
  logic clock = 0, reset = 1, tick = 0, enable = 1;
  logic [RW-1:0] seed = 6'h2A, rnd = 6'h05;
  logic [LANES*RW-1:0] density = '1;
  logic rng_load, busy;
  logic [RW-1:0] rng_start;
  logic [LANES-1:0] spawn;
  always #5 clock = ~clock;
  spawn_scheduler #(.LANES(LANES), .GAP_MIN(GAP), .RW(RW)) dut (
    .clock(clock), .reset(reset), .tick(tick), .enable(enable), .seed(seed), .rnd(rnd),
    .rng_load(rng_load), .rng_start(rng_start), .density(density), .spawn(spawn), .busy(busy)
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask
  // model: boot counts cycles since a seed load (3 = ready); a round is a queue of lanes still to try
  int boot = 0, ptr = 0;
  bit scanning = 0, pend = 0, m_valid = 0;
  int order[$];
  int gap[LANES];
  logic [LANES-1:0] m_spawn = '0;
  always @(posedge clock) begin
    int clr, l;
    clr = -1;
    m_spawn = '0;
    if (reset) begin
      boot = 0; scanning = 0; ptr = 0; pend = 0; m_valid = 1;
      order.delete();
      foreach (gap[i]) gap[i] = GAP;
    end else begin
      if (boot < 3) begin
        boot++;
        if (tick) pend = 1;
      end else if (!scanning) begin
        if ((tick || pend) && enable) begin
          pend = 0; scanning = 1;
          order.delete();
          for (int k = 0; k < LANES; k++) order.push_back((ptr + k) % LANES);
        end
      end else begin
        if (tick) pend = 1;
        if (rnd == 0) begin
          boot = 0; scanning = 0; pend = 1;
        end else begin
          l = order.pop_front();
          if (gap[l] == GAP && rnd < density[l*RW +: RW]) begin
            m_spawn[l] = 1'b1; clr = l; ptr = (l + 1) % LANES; scanning = 0;
          end else if (order.size() == 0) scanning = 0;
        end
      end
      for (int i = 0; i < LANES; i++)
        if (i == clr) gap[i] = 0;
        else if (tick && gap[i] < GAP) gap[i]++;
    end
  end
  initial begin
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      if (c < 2) reset = 1;
      else if (c < 8) begin reset = 0; tick = 0; end
      else if (c == 8) begin reset = 1; seed = '0; end
      else if (c < 15) begin reset = 0; tick = 0; end
      else if (c < 120) begin
        density = '1; rnd = 6'h05; enable = 1; seed = 6'h11;
        tick = (c % 10) == 0;
      end else begin
        reset  = $urandom_range(0, 299) == 0;
        tick   = $urandom_range(0, 3) == 0;
        enable = $urandom_range(0, 7) != 0;
        rnd    = $urandom_range(0, 15) == 0 ? '0 : RW'($urandom);
        if ($urandom_range(0, 63) == 0) seed = $urandom_range(0, 3) == 0 ? '0 : RW'($urandom);
        if (c % 64 == 0)
          for (int i = 0; i < LANES; i++)
            case ($urandom_range(0, 2))
              0: density[i*RW +: RW] = '0;
              1: density[i*RW +: RW] = '1;
              default: density[i*RW +: RW] = RW'($urandom);
            endcase
      end
      @(negedge clock);
      if (c == 2) begin
        chk("boot_load", rng_load, 1);
        chk("boot_start", rng_start, 6'h2A);
      end
      if (c == 4) chk("boot_busy", busy, 1);
      if (c == 5) chk("boot_idle", busy, 0);
      if (c == 9) chk("zero_seed", rng_start, 6'h01);
      if (m_valid) begin
        chk("spawn", spawn, m_spawn);
        chk("busy", busy, (boot < 3) || scanning);
        chk("rng_load", rng_load, (boot == 0) && !reset);
        chk("rng_start", rng_start, seed == 0 ? 1 : seed);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Per-frame scheduler that decides which road/river lane spawns a new obstacle.
- Shares one free-running 6-bit LFSR random source between LANES requesters using round-robin order, with a per-lane density threshold and minimum-gap enforcement.
- Owns LFSR seeding: drives the LFSR's reset/load line and seed value, and recovers the LFSR from the all-zero lock-up state.
- Sits between the frame-tick generator and the lane shift-register logic.

Parameters:
- LANES, 4, number of obstacle lanes served.
- GAP_MIN, 3, minimum ticks between two spawns on one lane (1..15).
- RW, 6, random word width; equals the LFSR width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame pulse that requests a scheduling round
- enable  in  1  0 = rounds are suppressed; gap counters still run
- seed  in  RW  seed applied to the LFSR on every load
- rnd  in  RW  registered output of the LFSR (advances every clock)
- rng_load  out  1  drives the LFSR reset/load input
- rng_start  out  RW  drives the LFSR start input; a seed of 0 is substituted with 1
- density  in  LANES*RW  per-lane threshold, lane i at bits [i*RW +: RW]; a spawn requires rnd < density_i
- spawn  out  LANES  one-hot, one-cycle spawn pulse
- busy  out  1  high while not in IDLE

Behaviour:
- Reset values:
  - spawn=0, busy=1, rng_load=0, ptr=0, pending=0.
  - Gap counters are set to GAP_MIN, so every lane is eligible immediately.
  - The FSM enters SEED.
- SEED (1 cycle):
  - rng_load=1, rng_start = (seed==0 ? 1 : seed).
  - Next state is WARM.
- WARM (2 cycles):
  - Covers the LFSR load plus its output register; rnd is ignored.
  - Next state is IDLE.
- IDLE:
  - busy=0.
  - If (tick or pending) and enable: clear pending, set idx=ptr, count=0, go to SCAN.
  - If tick arrives while enable=0: it is dropped; no round runs.
- SCAN (1 cycle per lane):
  - Zero check first: if rnd==0, go to SEED. The round is abandoned and pending is set.
  - Otherwise, lane idx fires when gap[idx]==GAP_MIN and rnd < density[idx].
  - On fire:
    - spawn[idx] is registered high for the next cycle only.
    - gap[idx] clears to 0.
    - ptr becomes (idx+1) mod LANES.
    - Go to IDLE.
  - On no fire:
    - idx increments mod LANES and count increments.
    - When count reaches LANES-1 without a fire, go to IDLE with ptr unchanged.
- Round limits:
  - At most one spawn per round; the round-robin pointer gives fairness.
  - A round takes at most LANES cycles. Spawn latency from tick is 2 to LANES+1 cycles.
- Gap counters:
  - Each lane's counter increments on every tick and saturates at GAP_MIN, independent of FSM state and enable.
  - A spawn clear in the same cycle as a tick takes priority; the result is 0.
- Tick while busy: sets pending. It is a one-deep latch, so further ticks collapse into it.
- Density boundaries: density=0 never spawns; density=2^RW-1 spawns unless rnd==2^RW-1.
- reset asserted mid-round: takes effect on the next edge. Any spawn pulse in flight is cleared and the full reset sequence (SEED, WARM) reruns.

Optional Feature:
- Macro: SPAWN_SCHED_STATS_EN.
- Defined:
  - Adds output spawn_total [15:0] and output rng_reseeds [7:0].
  - spawn_total counts spawn pulses and saturates at 0xFFFF.
  - rng_reseeds counts zero-lock recoveries; the reset-entered SEED is not counted. It saturates at 0xFF.
  - Both counters clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package (game_pkg):
  - Typedef sched_state_t with states SEED, WARM, IDLE, SCAN.
  - Constant RW_DEF=6.
  - Constant SEED_FALLBACK=6'b000001.
- One natural sub-module, lane_gap_counter: one saturating counter per lane, with tick and clear inputs and an eligible output. It is instantiated LANES times.

Test Plan:
- Reset, then check the seeding sequence: seed=6'h2A, reset for 1 cycle → rng_load=1 for exactly one cycle with rng_start=6'h2A, busy falls 3 cycles later; seed=0 → rng_start=6'h01.
- Round-robin: all densities 6'h3F, rnd forced to 6'h05, GAP_MIN=1, tick every 10 cycles → spawn sequence is 0001, 0010, 0100, 1000, 0001.
- Gap enforcement: one lane with density 6'h3F, others 0, GAP_MIN=3, tick every 10 cycles → spawns on ticks 1, 4, 7 only.
- Density boundary: density lane0 = 6'h10; rnd=6'h0F → spawn[0]; rnd=6'h10 → no spawn; round ends after 4 SCAN cycles with ptr unchanged.
- Zero lock-up: force rnd=0 during SCAN → rng_load pulses and pending is set; after WARM with rnd=6'h01, the round reruns without a new tick.
- Pending collapse: 3 ticks during one round → exactly one extra round; with enable=0, tick gives no round while gap counters still advance.
